// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one 32-bit combinational ALU between two requesters.
// One operation is in flight at a time: IDLE accepts a request, EXEC lets the
// ALU evaluate the registered operands, and RESP holds the registered response
// for the owning requester until it is consumed.

// Combinational ALU used by the arbiter.
module alu_share_alu #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [W-1:0]   result_o,
    output logic           zero_o,
    output logic           overflow_o
);

    localparam int SHW = $clog2(W);

    localparam logic [OPW-1:0] OP_AND = 4'b0000;
    localparam logic [OPW-1:0] OP_OR  = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB = 4'b0110;
    localparam logic [OPW-1:0] OP_SLT = 4'b0111;
    localparam logic [OPW-1:0] OP_SGE = 4'b1000;
    localparam logic [OPW-1:0] OP_SLL = 4'b1001;
    localparam logic [OPW-1:0] OP_SRL = 4'b1010;
    localparam logic [OPW-1:0] OP_NOR = 4'b1100;

    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic         w_lt;
    logic         w_add_ovf;

    // Shared arithmetic terms: sum, difference, signed less-than and ADD overflow.
    always_comb begin
        w_sum     = a_i + b_i;
        w_diff    = a_i - b_i;
        w_lt      = ($signed(a_i) < $signed(b_i));
        // Signed overflow: operands agree in sign but the sum does not.
        w_add_ovf = (a_i[W-1] == b_i[W-1]) && (w_sum[W-1] != a_i[W-1]);
    end

    // Operation select; unknown codes yield a zero result (and so a set zero flag).
    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_ADD: begin
                result_o   = w_sum;
                overflow_o = w_add_ovf;
            end
            OP_SUB: result_o = w_diff;
            OP_SLT: result_o = {{(W-1){1'b0}}, w_lt};
            OP_SGE: result_o = {{(W-1){1'b0}}, ~w_lt};
            OP_SLL: result_o = a_i << b_i[SHW-1:0];
            OP_SRL: result_o = a_i >> b_i[SHW-1:0];
            OP_NOR: result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// Two-port arbiter wrapping the shared ALU.
module alu_share_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,

    input  logic           req0_valid_i,
    output logic           req0_ready_o,
    input  logic [OPW-1:0] req0_op_i,
    input  logic [W-1:0]   req0_src1_i,
    input  logic [W-1:0]   req0_src2_i,

    input  logic           req1_valid_i,
    output logic           req1_ready_o,
    input  logic [OPW-1:0] req1_op_i,
    input  logic [W-1:0]   req1_src1_i,
    input  logic [W-1:0]   req1_src2_i,

    output logic           rsp0_valid_o,
    input  logic           rsp0_ready_i,
    output logic           rsp1_valid_o,
    input  logic           rsp1_ready_i,
    output logic [W-1:0]   rsp_result_o,
    output logic           rsp_zero_o,
    output logic           rsp_overflow_o,

    output logic           busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic           r_prio;
    logic           r_owner;
    logic [OPW-1:0] r_op;
    logic [W-1:0]   r_src1;
    logic [W-1:0]   r_src2;
    logic [W-1:0]   r_result;
    logic           r_zero;
    logic           r_overflow;
    logic           r_rsp0_valid;
    logic           r_rsp1_valid;

    logic           w_grant_port;
    logic           w_accept;
    logic [OPW-1:0] w_sel_op;
    logic [W-1:0]   w_sel_src1;
    logic [W-1:0]   w_sel_src2;
    logic [W-1:0]   w_alu_result;
    logic           w_alu_zero;
    logic           w_alu_overflow;
    logic           w_rsp_taken;

    // Grant selection: a lone valid port wins; with two valid ports the priority pointer decides.
    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            w_grant_port = r_prio;
        end else begin
            w_grant_port = req1_valid_i;
        end
        // Ready is held low while reset is asserted so no handshake is seen during reset.
        w_accept     = (r_state == S_IDLE) && (req0_valid_i || req1_valid_i) && !rst_i;
        req0_ready_o = w_accept && !w_grant_port;
        req1_ready_o = w_accept &&  w_grant_port;
    end

    // Operand mux feeding the issue registers.
    always_comb begin
        if (w_grant_port) begin
            w_sel_op   = req1_op_i;
            w_sel_src1 = req1_src1_i;
            w_sel_src2 = req1_src2_i;
        end else begin
            w_sel_op   = req0_op_i;
            w_sel_src1 = req0_src1_i;
            w_sel_src2 = req0_src2_i;
        end
    end

    // Response consumption only listens to the owner's ready.
    always_comb begin
        w_rsp_taken = r_owner ? rsp1_ready_i : rsp0_ready_i;
    end

    alu_share_alu #(
        .W   (W),
        .OPW (OPW)
    ) u_alu (
        .op_i       (r_op),
        .a_i        (r_src1),
        .b_i        (r_src2),
        .result_o   (w_alu_result),
        .zero_o     (w_alu_zero),
        .overflow_o (w_alu_overflow)
    );

    // Control FSM: accept in IDLE, evaluate in EXEC, hold response in RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant_port;
                        r_prio  <= ~w_grant_port;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <=  r_owner;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_taken) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Issue registers capture the granted operation on the handshake edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op   <= '0;
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (w_accept) begin
            r_op   <= w_sel_op;
            r_src1 <= w_sel_src1;
            r_src2 <= w_sel_src2;
        end
    end

    // Response registers capture the ALU output at the end of EXEC and hold until consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_result   <= w_alu_result;
            r_zero     <= w_alu_zero;
            r_overflow <= w_alu_overflow;
        end
    end

    assign rsp0_valid_o   = r_rsp0_valid;
    assign rsp1_valid_o   = r_rsp1_valid;
    assign rsp_result_o   = r_result;
    assign rsp_zero_o     = r_zero;
    assign rsp_overflow_o = r_overflow;
    assign busy_o         = (r_state != S_IDLE);

endmodule
